// File: rtl/hazard_stall_unit_pkg.sv
// Shared types and constants for the hazard stall/flush controller.
package hazard_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned MDU_CW = 6;
  localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_BUSY = 1'b1
  } hazard_state_e;

endpackage

// File: rtl/hazard_stall_unit_mdu_busy_tracker.sv
// Tracks MDU occupancy: RUN/MDU_BUSY state plus down-counter of remaining busy cycles.
module mdu_busy_tracker
  import hazard_pkg::*;
#(
  parameter int unsigned MDU_LAT = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic issue,
  output logic busy
);

  hazard_state_e state, state_nx;
  logic [MDU_CW-1:0] mdu_cnt, mdu_cnt_nx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= RUN;
      mdu_cnt <= '0;
    end else begin
      state   <= state_nx;
      mdu_cnt <= mdu_cnt_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    mdu_cnt_nx = mdu_cnt;
    case (state)
      RUN: begin
        if (issue) begin
          state_nx   = MDU_BUSY;
          mdu_cnt_nx = MDU_CW'(MDU_LAT - 1);
        end
      end
      MDU_BUSY: begin
        // Counter keeps running regardless of pipeline freeze.
        if (mdu_cnt == '0) state_nx = RUN;
        else               mdu_cnt_nx = mdu_cnt - 6'd1;
      end
      default: state_nx = RUN;
    endcase
  end

  assign busy = (state == MDU_BUSY);

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage MIPS pipeline.
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int unsigned MDU_LAT = 32,
  parameter int unsigned PERF_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] IF_ID_rs,
  input  logic [REG_AW-1:0] IF_ID_rt,
  input  logic              ID_use_rt,
  input  logic              ID_branch,
  input  logic              ID_mdu,
  input  logic              ID_hilo_rd,
  input  logic              branch_taken,
  input  logic              ID_jump,
  input  logic              ID_EX_regwr,
  input  logic              ID_EX_memRd,
  input  logic [REG_AW-1:0] ID_EX_regwrad,
  input  logic              EX_MEM_regwr,
  input  logic              EX_MEM_memRd,
  input  logic              EX_MEM_memWr,
  input  logic [REG_AW-1:0] EX_MEM_regwrad,
  input  logic              dmem_ready,
  output logic              PC_wr,
  output logic              IF_ID_wr,
  output logic              IF_ID_flush,
  output logic              ID_EX_flush,
  output logic              EX_MEM_wr,
  output logic              MEM_WB_flush,
  output logic              mdu_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] perf_stall_cyc,
  output logic [PERF_W-1:0] perf_flush_cnt
`endif
);

  logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
  logic load_use, branch_hz, mdu_hz, id_stall, mem_freeze;
  logic busy, issue;

  assign ex_hit_rs  = (ID_EX_regwrad  != ZERO_REG) && (ID_EX_regwrad  == IF_ID_rs);
  assign ex_hit_rt  = (ID_EX_regwrad  != ZERO_REG) && (ID_EX_regwrad  == IF_ID_rt);
  assign mem_hit_rs = (EX_MEM_regwrad != ZERO_REG) && (EX_MEM_regwrad == IF_ID_rs);
  assign mem_hit_rt = (EX_MEM_regwrad != ZERO_REG) && (EX_MEM_regwrad == IF_ID_rt);

  assign load_use   = ID_EX_memRd && (ex_hit_rs || (ID_use_rt && ex_hit_rt));
  assign branch_hz  = ID_branch && ((ID_EX_regwr && (ex_hit_rs || ex_hit_rt)) ||
                                    (EX_MEM_regwr && (mem_hit_rs || mem_hit_rt)));
  assign mdu_hz     = busy && (ID_mdu || ID_hilo_rd);
  assign id_stall   = load_use || branch_hz || mdu_hz;
  assign mem_freeze = (EX_MEM_memRd || EX_MEM_memWr) && !dmem_ready;

  // Tracker only accepts an issue while in RUN.
  assign issue = rst_n && ID_mdu && !id_stall && !mem_freeze;

  mdu_busy_tracker #(.MDU_LAT(MDU_LAT)) u_mdu (
    .clk   (clk),
    .rst_n (rst_n),
    .issue (issue),
    .busy  (busy)
  );

  always_comb begin
    PC_wr        = 1'b1;
    IF_ID_wr     = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    EX_MEM_wr    = 1'b1;
    MEM_WB_flush = 1'b0;
    if (!rst_n) begin
      PC_wr        = 1'b0;
      IF_ID_wr     = 1'b0;
      IF_ID_flush  = 1'b1;
      ID_EX_flush  = 1'b1;
      EX_MEM_wr    = 1'b0;
      MEM_WB_flush = 1'b1;
    end else if (mem_freeze) begin
      PC_wr        = 1'b0;
      IF_ID_wr     = 1'b0;
      EX_MEM_wr    = 1'b0;
      MEM_WB_flush = 1'b1;
    end else if (id_stall) begin
      PC_wr       = 1'b0;
      IF_ID_wr    = 1'b0;
      ID_EX_flush = 1'b1;
    end else begin
      IF_ID_flush = branch_taken || ID_jump;
    end
  end

  assign mdu_busy = rst_n && busy;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_cyc <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (id_stall || mem_freeze) perf_stall_cyc <= perf_stall_cyc + 1'b1;
      if (IF_ID_flush)            perf_flush_cnt <= perf_flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: directed scenarios plus randomized run vs. reference model.
module tb_hazard_stall_unit;

  localparam int unsigned LAT = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] IF_ID_rs, IF_ID_rt, ID_EX_regwrad, EX_MEM_regwrad;
  logic ID_use_rt, ID_branch, ID_mdu, ID_hilo_rd, branch_taken, ID_jump;
  logic ID_EX_regwr, ID_EX_memRd, EX_MEM_regwr, EX_MEM_memRd, EX_MEM_memWr, dmem_ready;
  logic PC_wr, IF_ID_wr, IF_ID_flush, ID_EX_flush, EX_MEM_wr, MEM_WB_flush, mdu_busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cyc, perf_flush_cnt;
`endif

  logic [6:0] outs;
  assign outs = {PC_wr, IF_ID_wr, IF_ID_flush, ID_EX_flush, EX_MEM_wr, MEM_WB_flush, mdu_busy};

  int checks = 0;
  int fails  = 0;
  int mdu_left = 0;  // reference: cycles of MDU occupancy still to come

  always #5 clk = ~clk;

  hazard_stall_unit #(.MDU_LAT(LAT), .PERF_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt), .ID_use_rt(ID_use_rt),
    .ID_branch(ID_branch), .ID_mdu(ID_mdu), .ID_hilo_rd(ID_hilo_rd),
    .branch_taken(branch_taken), .ID_jump(ID_jump),
    .ID_EX_regwr(ID_EX_regwr), .ID_EX_memRd(ID_EX_memRd), .ID_EX_regwrad(ID_EX_regwrad),
    .EX_MEM_regwr(EX_MEM_regwr), .EX_MEM_memRd(EX_MEM_memRd), .EX_MEM_memWr(EX_MEM_memWr),
    .EX_MEM_regwrad(EX_MEM_regwrad), .dmem_ready(dmem_ready),
    .PC_wr(PC_wr), .IF_ID_wr(IF_ID_wr), .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
    .EX_MEM_wr(EX_MEM_wr), .MEM_WB_flush(MEM_WB_flush), .mdu_busy(mdu_busy)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  // Reference model: what the spec rules demand for the current inputs and MDU occupancy.
  function automatic logic model_freeze();
    return (EX_MEM_memRd || EX_MEM_memWr) && !dmem_ready;
  endfunction

  function automatic logic model_stall();
    logic lu, br, md;
    lu = ID_EX_memRd && ID_EX_regwrad != 0 &&
         (ID_EX_regwrad == IF_ID_rs || (ID_use_rt && ID_EX_regwrad == IF_ID_rt));
    br = ID_branch &&
         ((ID_EX_regwr && ID_EX_regwrad != 0 && (ID_EX_regwrad == IF_ID_rs || ID_EX_regwrad == IF_ID_rt)) ||
          (EX_MEM_regwr && EX_MEM_regwrad != 0 && (EX_MEM_regwrad == IF_ID_rs || EX_MEM_regwrad == IF_ID_rt)));
    md = (mdu_left > 0) && (ID_mdu || ID_hilo_rd);
    return lu || br || md;
  endfunction

  function automatic logic [6:0] model_out();
    logic b;
    b = (mdu_left > 0);
    if (!rst_n)         return 7'b0011010;
    if (model_freeze()) return {6'b000001, b};
    if (model_stall())  return {6'b000110, b};
    return {2'b11, (branch_taken || ID_jump), 3'b010, b};
  endfunction

  task automatic idle();
    rst_n = 1'b1;
    IF_ID_rs = 0; IF_ID_rt = 0; ID_EX_regwrad = 0; EX_MEM_regwrad = 0;
    ID_use_rt = 0; ID_branch = 0; ID_mdu = 0; ID_hilo_rd = 0; branch_taken = 0; ID_jump = 0;
    ID_EX_regwr = 0; ID_EX_memRd = 0; EX_MEM_regwr = 0; EX_MEM_memRd = 0; EX_MEM_memWr = 0;
    dmem_ready = 1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Clock one edge and advance the reference MDU occupancy with the inputs seen at that edge.
  task automatic advance();
    logic iss;
    iss = rst_n && mdu_left == 0 && ID_mdu && !model_stall() && !model_freeze();
    @(posedge clk);
    if (!rst_n)            mdu_left = 0;
    else if (mdu_left > 0) mdu_left = mdu_left - 1;
    else if (iss)          mdu_left = LAT;
    #1;
  endtask

  task automatic test_reset();
    idle(); rst_n = 0; ID_mdu = 1; branch_taken = 1; settle();
    checks++;
    if (outs !== 7'b0011010) begin fails++; $display("FAIL reset_outputs: got %b expected %b", outs, 7'b0011010); end
    advance();
    idle(); settle();
    checks++;
    if (outs !== 7'b1100100) begin fails++; $display("FAIL reset_release: got %b expected %b", outs, 7'b1100100); end
    advance();
  endtask

  task automatic test_load_use();
    idle(); ID_EX_memRd = 1; ID_EX_regwr = 1; ID_EX_regwrad = 2; IF_ID_rs = 2; IF_ID_rt = 4; ID_use_rt = 1;
    settle();
    checks++;
    if (outs !== 7'b0001100) begin fails++; $display("FAIL load_use_stall: got %b expected %b", outs, 7'b0001100); end
    advance();
    idle(); EX_MEM_memRd = 1; EX_MEM_regwr = 1; EX_MEM_regwrad = 2; IF_ID_rs = 2; IF_ID_rt = 4; ID_use_rt = 1;
    settle();
    checks++;
    if (outs !== 7'b1100100) begin fails++; $display("FAIL load_use_release: got %b expected %b", outs, 7'b1100100); end
    advance();
  endtask

  task automatic test_load_branch();
    idle(); ID_EX_memRd = 1; ID_EX_regwr = 1; ID_EX_regwrad = 2; ID_branch = 1; IF_ID_rs = 2; IF_ID_rt = 5;
    settle();
    checks++;
    if (outs !== 7'b0001100) begin fails++; $display("FAIL load_branch_stall1: got %b expected %b", outs, 7'b0001100); end
    advance();
    idle(); EX_MEM_memRd = 1; EX_MEM_regwr = 1; EX_MEM_regwrad = 2; ID_branch = 1; IF_ID_rs = 2; IF_ID_rt = 5;
    settle();
    checks++;
    if (outs !== 7'b0001100) begin fails++; $display("FAIL load_branch_stall2: got %b expected %b", outs, 7'b0001100); end
    advance();
    idle(); ID_branch = 1; branch_taken = 1; IF_ID_rs = 2; IF_ID_rt = 5;
    settle();
    checks++;
    if (outs !== 7'b1110100) begin fails++; $display("FAIL load_branch_taken: got %b expected %b", outs, 7'b1110100); end
    advance();
    idle(); settle();
    checks++;
    if (outs !== 7'b1100100) begin fails++; $display("FAIL load_branch_after: got %b expected %b", outs, 7'b1100100); end
    advance();
  endtask

  task automatic test_zero_reg();
    idle(); ID_EX_memRd = 1; ID_EX_regwr = 1; ID_EX_regwrad = 0; IF_ID_rs = 0; settle();
    checks++;
    if (outs !== 7'b1100100) begin fails++; $display("FAIL zero_reg_load: got %b expected %b", outs, 7'b1100100); end
    advance();
    idle(); ID_EX_memRd = 1; ID_EX_regwrad = 3; IF_ID_rs = 1; IF_ID_rt = 3; ID_use_rt = 0; settle();
    checks++;
    if (outs !== 7'b1100100) begin fails++; $display("FAIL rt_unused: got %b expected %b", outs, 7'b1100100); end
    advance();
    idle(); ID_branch = 1; EX_MEM_regwr = 1; EX_MEM_regwrad = 0; IF_ID_rs = 0; IF_ID_rt = 0; settle();
    checks++;
    if (outs !== 7'b1100100) begin fails++; $display("FAIL zero_reg_branch: got %b expected %b", outs, 7'b1100100); end
    advance();
  endtask

  task automatic test_mdu();
    idle(); ID_mdu = 1; settle();
    checks++;
    if (outs !== 7'b1100100) begin fails++; $display("FAIL mdu_issue: got %b expected %b", outs, 7'b1100100); end
    advance();
    for (int unsigned c = 0; c < LAT; c++) begin
      idle(); ID_hilo_rd = 1; settle();
      checks++;
      if (outs !== 7'b0001101) begin fails++; $display("FAIL mflo_stall c%0d: got %b expected %b", c, outs, 7'b0001101); end
      advance();
    end
    idle(); ID_hilo_rd = 1; settle();
    checks++;
    if (outs !== 7'b1100100) begin fails++; $display("FAIL mflo_issue: got %b expected %b", outs, 7'b1100100); end
    advance();
  endtask

  task automatic test_mdu_freeze();
    idle(); ID_mdu = 1; settle(); advance();
    for (int unsigned c = 0; c < 2; c++) begin
      idle(); ID_mdu = 1; EX_MEM_memWr = 1; dmem_ready = 0; settle();
      checks++;
      if (outs !== 7'b0000011) begin fails++; $display("FAIL mdu_freeze c%0d: got %b expected %b", c, outs, 7'b0000011); end
      advance();
    end
    for (int unsigned c = 0; c < LAT - 2; c++) begin
      idle(); ID_mdu = 1; settle();
      checks++;
      if (outs !== 7'b0001101) begin fails++; $display("FAIL mdu_held c%0d: got %b expected %b", c, outs, 7'b0001101); end
      advance();
    end
    idle(); ID_mdu = 1; settle();
    checks++;
    if (outs !== 7'b1100100) begin fails++; $display("FAIL mdu_reissue: got %b expected %b", outs, 7'b1100100); end
    advance();
    idle(); settle();
    checks++;
    if (outs !== 7'b1100101) begin fails++; $display("FAIL mdu_busy_again: got %b expected %b", outs, 7'b1100101); end
    advance();
  endtask

  task automatic test_reset_mid_mdu();
    idle(); rst_n = 0; settle();
    checks++;
    if (outs !== 7'b0011010) begin fails++; $display("FAIL reset_mid_mdu: got %b expected %b", outs, 7'b0011010); end
    advance();
    idle(); settle();
    checks++;
    if (outs !== 7'b1100100) begin fails++; $display("FAIL after_reset_mdu: got %b expected %b", outs, 7'b1100100); end
    advance();
  endtask

  task automatic test_mem_freeze();
    for (int unsigned c = 0; c < 3; c++) begin
      idle(); EX_MEM_memRd = 1; dmem_ready = 0; ID_branch = 1; branch_taken = 1; IF_ID_rs = 6; settle();
      checks++;
      if (outs !== 7'b0000010) begin fails++; $display("FAIL freeze c%0d: got %b expected %b", c, outs, 7'b0000010); end
      advance();
    end
    idle(); EX_MEM_memRd = 1; dmem_ready = 1; ID_branch = 1; branch_taken = 1; IF_ID_rs = 6; settle();
    checks++;
    if (outs !== 7'b1110100) begin fails++; $display("FAIL thaw_flush: got %b expected %b", outs, 7'b1110100); end
    advance();
  endtask

  task automatic test_random();
    logic [6:0] exp;
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 39) != 0);
      IF_ID_rs = 5'($urandom_range(0, 3)); IF_ID_rt = 5'($urandom_range(0, 3));
      ID_EX_regwrad = 5'($urandom_range(0, 3)); EX_MEM_regwrad = 5'($urandom_range(0, 3));
      ID_use_rt = 1'($urandom); ID_branch = ($urandom_range(0, 3) == 0);
      ID_mdu = ($urandom_range(0, 4) == 0); ID_hilo_rd = ($urandom_range(0, 4) == 0);
      branch_taken = 1'($urandom); ID_jump = ($urandom_range(0, 5) == 0);
      ID_EX_regwr = 1'($urandom); ID_EX_memRd = ($urandom_range(0, 3) == 0);
      EX_MEM_regwr = 1'($urandom); EX_MEM_memRd = ($urandom_range(0, 3) == 0);
      EX_MEM_memWr = ($urandom_range(0, 5) == 0); dmem_ready = ($urandom_range(0, 3) != 0);
      settle();
      exp = model_out();
      checks++;
      if (outs !== exp) begin fails++; $display("FAIL random cyc%0d: got %b expected %b", i, outs, exp); end
      advance();
    end
  endtask

  initial begin
    idle(); rst_n = 0;
    @(posedge clk); #1;
    mdu_left = 0;
    test_reset();
    test_load_use();
    test_load_branch();
    test_zero_reg();
    test_mdu();
    test_mdu_freeze();
    test_reset_mid_mdu();
    test_mem_freeze();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
